// File: rtl/sram_controller_if.sv
// sram_controller_if: MEM-stage request bus and 16-bit SRAM pins of the SRAM controller
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );
  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );
endinterface

// File: rtl/sram_controller.sv
// sram_controller: splits a 32-bit pipeline load/store into two timed 16-bit SRAM half-accesses
module sram_controller #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  sram_controller_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;
  localparam logic [31:0] BASE   = 32'(ADDR_BASE);
  localparam logic [3:0]  RELOAD = 4'(WAIT_CYCLES - 1);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        wr_q, wr_d;
  logic [17:0] sa_q, sa_d;
  logic        we_n_q, we_n_d, oe_q, oe_d;
  logic [15:0] dq_q, dq_d;
  logic        req, last, acc, hi;
  logic [16:0] idx;
  assign req  = bus.rd_en | bus.wr_en;
  assign last = cnt_q == 4'd0;
  assign bus.ready       = !((state_q == IDLE && req) || state_q == ACC_LO || state_q == ACC_HI);
  assign bus.read_data   = rdata_q;
  assign bus.sram_addr   = sa_q;
  assign bus.sram_we_n   = we_n_q;
  assign bus.sram_dq_out = dq_q;
  assign bus.sram_dq_oe  = oe_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? cnt_q : cnt_q - 4'd1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = ACC_LO;
        cnt_d   = RELOAD;
        addr_d  = bus.address;
        wdata_d = bus.write_data;
        wr_d    = bus.wr_en;
      end
      ACC_LO: if (last) begin
        state_d        = ACC_HI;
        cnt_d          = RELOAD;
        rdata_d[15:0]  = wr_q ? rdata_q[15:0] : bus.sram_dq_in;
      end
      ACC_HI: if (last) begin
        state_d        = DONE;
        rdata_d[31:16] = wr_q ? rdata_q[31:16] : bus.sram_dq_in;
      end
      default: state_d = IDLE;
    endcase
    // SRAM pins are registered, so they are computed for the state being entered
    acc    = state_d == ACC_LO || state_d == ACC_HI;
    hi     = state_d == ACC_HI;
    idx    = 17'((addr_d - BASE) >> 2);
    sa_d   = acc ? {idx, hi} : sa_q;
    we_n_d = !(acc && wr_d);
    oe_d   = acc && wr_d;
    dq_d   = (acc && wr_d) ? (hi ? wdata_d[31:16] : wdata_d[15:0]) : dq_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      sa_q    <= '0;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      dq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      sa_q    <= sa_d;
      we_n_q  <= we_n_d;
      oe_q    <= oe_d;
      dq_q    <= dq_d;
    end
  end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: random load/store traffic checked cycle-by-cycle against a word-level memory model
module tb_sram_controller;
  localparam int W  = 2;
  localparam int AB = 1024;
  typedef struct {
    logic        rdy;
    logic        ca;
    logic [17:0] a;
    logic        wen;
    logic        oe;
    logic        cd;
    logic [15:0] dq;
    logic        cr;
    logic [31:0] rd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  sram_controller_if bus ();
  sram_controller #(.ADDR_BASE(AB), .WAIT_CYCLES(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic [31:0] exp_mem[int];
  logic [31:0] cur_rd = '0;
  logic [15:0] dev [0:262143];
  logic dev_ready = 1'b0;
  function automatic logic [15:0] init(input logic [17:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction
  function automatic logic [16:0] widx(input logic [31:0] a);
    longint o = (longint'(a) - AB) & 64'hFFFF_FFFF;
    return 17'(o / 4);
  endfunction
  function automatic logic [31:0] mword(input logic [16:0] ix);
    if (exp_mem.exists(int'(ix))) return exp_mem[int'(ix)];
    return {init({ix, 1'b1}), init({ix, 1'b0})};
  endfunction
  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, expv);
    end
  endfunction
  // SRAM device: asynchronous read, write on the edge while we_n is low
  assign bus.sram_dq_in = dev[bus.sram_addr];
  always @(posedge clk) begin
    if (!dev_ready) begin
      for (int i = 0; i < 262144; i++) dev[i] <= init(18'(i));
      dev[2] <= 16'h1234;
      dev[3] <= 16'h5678;
      dev_ready <= 1'b1;
    end else if (!bus.sram_we_n) dev[bus.sram_addr] <= bus.sram_dq_out;
  end
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("ready", 32'(bus.ready), 32'(cur.rdy));
      chk("sram_we_n", 32'(bus.sram_we_n), 32'(cur.wen));
      chk("sram_dq_oe", 32'(bus.sram_dq_oe), 32'(cur.oe));
      if (cur.ca) chk("sram_addr", 32'(bus.sram_addr), 32'(cur.a));
      if (cur.cd) chk("sram_dq_out", 32'(bus.sram_dq_out), 32'(cur.dq));
      if (cur.cr) chk("read_data", bus.read_data, cur.rd);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic px(input logic rdy, input logic ca, input logic [17:0] a, input logic wen,
                    input logic oe, input logic cd, input logic [15:0] dq, input logic cr,
                    input logic [31:0] rd);
    exp_t e;
    e.rdy = rdy; e.ca = ca; e.a = a; e.wen = wen; e.oe = oe;
    e.cd = cd; e.dq = dq; e.cr = cr; e.rd = rd;
    exp_q.push_back(e);
  endtask
  task automatic idle();
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.address = $urandom;
    bus.write_data = $urandom;
    px(1, 0, '0, 1, 0, 0, '0, 1, cur_rd);
  endtask
  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    bus.wr_en = w;
    bus.rd_en = r;
    bus.address = a;
    bus.write_data = d;
  endtask
  // request cycle, W cycles per half, then the one-cycle completion
  task automatic xact(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    logic [16:0] ix;
    logic hb;
    ix = widx(a);
    tick();
    drive(w, r, a, d);
    px(0, 0, '0, 1, 0, 0, '0, 1, cur_rd);
    for (int h = 0; h < 2; h++) begin
      hb = h == 1;
      for (int k = 0; k < W; k++) begin
        tick();
        px(0, 1, {ix, hb}, !w, w, w, hb ? d[31:16] : d[15:0], 0, '0);
      end
    end
    tick();
    drive($urandom, $urandom, $urandom, $urandom);
    if (w) exp_mem[int'(ix)] = d;
    else cur_rd = mword(ix);
    px(1, 0, '0, 1, 0, 0, '0, 1, cur_rd);
  endtask
  task automatic reset_in_hi(input logic [31:0] a, input logic [31:0] d);
    logic [16:0] ix;
    ix = widx(a);
    tick();
    drive(1, 0, a, d);
    px(0, 0, '0, 1, 0, 0, '0, 1, cur_rd);
    for (int k = 0; k < W; k++) begin
      tick();
      px(0, 1, {ix, 1'b0}, 0, 1, 1, d[15:0], 0, '0);
    end
    tick();
    rst = 1'b1;
    px(0, 1, {ix, 1'b1}, 0, 1, 1, d[31:16], 0, '0);
    tick();
    rst = 1'b0;
    drive(0, 0, '0, '0);
    exp_mem[int'(ix)] = d;
    cur_rd = '0;
    px(1, 1, '0, 1, 0, 1, '0, 1, '0);
    for (int k = 0; k < 2 * W + 1; k++) idle();
  endtask
  initial begin
    logic w, r;
    logic [31:0] a;
    drive(0, 0, '0, '0);
    exp_mem[1] = 32'h5678_1234;
    chk("model_idx_base", 32'(widx(32'd1024)), 32'h0);
    chk("model_idx_below", 32'(widx(32'd0)), 32'h1FF00);
    chk("model_idx_wrap", 32'(widx(32'h0008_0400)), 32'h0);
    tick();
    px(1, 1, '0, 1, 0, 1, '0, 1, '0);
    tick();
    rst = 1'b0;
    xact(1, 0, 32'd1024, 32'hDEAD_BEEF);
    xact(0, 1, 32'd1028, 32'h0);
    chk("model_read_1028", cur_rd, 32'h5678_1234);
    idle();
    xact(1, 1, 32'd1032, 32'hCAFE_F00D);
    chk("model_rdwr_keeps", cur_rd, 32'h5678_1234);
    xact(1, 0, 32'd1024, 32'hDEAD_BEEF);
    xact(0, 1, 32'd1024, 32'h0);
    chk("model_b2b_read", cur_rd, 32'hDEAD_BEEF);
    idle();
    xact(1, 0, 32'd0, 32'h0BAD_C0DE);
    xact(0, 1, 32'd3, 32'h0);
    chk("model_wrap_read", cur_rd, 32'h0BAD_C0DE);
    reset_in_hi(32'd1100, 32'h1357_9BDF);
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 2)) idle();
      w = 1'($urandom);
      r = w ? 1'($urandom) : 1'b1;
      a = ($urandom_range(0, 19) == 0) ? $urandom : 32'(AB + $urandom_range(0, 127));
      xact(w, r, a, $urandom);
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
